// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 serial receiver.
// Imported by uart_rx_core.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/uart_rx_core_sync_ff.sv
// Generic N-stage synchroniser for an asynchronous single-bit input.
// Async active-high reset loads every stage with RST_VAL.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr_q;
  logic [STAGES-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= {STAGES{RST_VAL}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: mid-bit sampling with a runtime divider.
// Emits one-cycle valid / frame_err pulses; data holds the last good byte.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_rx,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  output logic [7:0]           data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic                 rx_s;
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic [DIV_WIDTH-1:0] div_eff;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ser_rx),
    .q     (rx_s)
  );

  assign div_eff = (cfg_divider < DIV_MIN) ? DIV_MIN : cfg_divider;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          cnt_d   = div_q - ONE;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = div_q - ONE;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (rx_s) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        // a held-low line stays here so it reports only once
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core.
// Scoreboard of expected bytes plus a small vector table and corner sequences.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_rx;
  logic [31:0] cfg_divider;
  logic [7:0]  data;
  logic        valid;
  logic        frame_err;
  logic        busy;

  uart_rx_core #(
    .DIV_WIDTH   (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ser_rx      (ser_rx),
    .cfg_divider (cfg_divider),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    int          bc;
    logic [31:0] cfg;
    int          gap;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t        tab [8];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  int          valid_cnt = 0;
  int          fe_cnt = 0;
  int          last_valid_cyc = 0;
  logic        valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      valid_prev = 1'b0;
    end else begin
      if (valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        check("valid_with_frame_err", frame_err, 0);
        check("valid_back_to_back", valid_prev, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid data=%0h exp=none", data);
        end else begin
          check("scoreboard_data", data, exp_q.pop_front());
        end
      end
      if (frame_err) fe_cnt++;
      valid_prev = valid;
    end
  end

  task automatic send_frame(input logic [7:0] b, input int bc,
                            input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = fr[i];
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cfg_divider = tab[i].cfg;
      exp_q.push_back(tab[i].exp_data);
      send_frame(tab[i].b, tab[i].bc, 1'b1);
      ser_rx = 1'b1;
      repeat (tab[i].gap * tab[i].bc) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int f0;
    int t0;
    int lat;
    int act;
    logic [9:0] fr;

    tab[0] = '{8'h0D, 217, 32'd217, 0, 8'h0D};
    tab[1] = '{8'h0A, 217, 32'd217, 0, 8'h0A};
    tab[2] = '{8'h7E, 217, 32'd217, 0, 8'h7E};
    tab[3] = '{8'hC3, 4,   32'd4,   2, 8'hC3};
    tab[4] = '{8'h5A, 4,   32'd1,   2, 8'h5A};
    tab[5] = '{8'hFF, 4,   32'd3,   2, 8'hFF};
    tab[6] = '{8'h00, 4,   32'd0,   2, 8'h00};
    tab[7] = '{8'h81, 9,   32'd9,   0, 8'h81};

    reset = 1'b1;
    ser_rx = 1'b1;
    cfg_divider = 32'd217;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    act = 0;
    repeat (10000) begin
      @(negedge clk);
      if (valid || frame_err || busy) act++;
    end
    check("idle_activity", act, 0);
    check("idle_data", data, 0);

    v0 = valid_cnt;
    t0 = cyc;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 217, 1'b1);
    repeat (217) @(negedge clk);
    drain("drain_41", 1000);
    check("count_41", valid_cnt - v0, 1);
    check("data_41", data, 8'h41);
    lat = last_valid_cyc - t0;
    checks++;
    if (lat < 2061 || lat > 2069) begin
      errors++;
      $display("FAIL latency_41 act=%0d exp=2065+/-4", lat);
    end

    v0 = valid_cnt;
    f0 = fe_cnt;
    apply(0, 2);
    repeat (217) @(negedge clk);
    drain("drain_b2b", 2000);
    check("count_b2b", valid_cnt - v0, 3);
    check("fe_b2b", fe_cnt - f0, 0);
    check("data_b2b_last", data, 8'h7E);

    v0 = valid_cnt;
    ser_rx = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (35) @(negedge clk);
    ser_rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", valid_cnt - v0, 0);

    exp_q.push_back(8'h55);
    send_frame(8'h55, 217, 1'b1);
    repeat (217) @(negedge clk);
    drain("drain_55", 1000);
    check("data_55", data, 8'h55);

    v0 = valid_cnt;
    f0 = fe_cnt;
    send_frame(8'hA5, 217, 1'b0);
    repeat (30 * 217) @(negedge clk);
    check("ferr_count", fe_cnt - f0, 1);
    check("ferr_no_valid", valid_cnt - v0, 0);
    check("ferr_data_kept", data, 8'h55);
    check("break_busy", busy, 1);
    ser_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_exit_busy", busy, 0);

    exp_q.push_back(8'h33);
    send_frame(8'h33, 217, 1'b1);
    repeat (217) @(negedge clk);
    drain("drain_33", 1000);
    check("data_33", data, 8'h33);

    v0 = valid_cnt;
    f0 = fe_cnt;
    fr = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ser_rx = fr[i];
      repeat (217) @(negedge clk);
    end
    ser_rx = fr[5];
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_data", data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", frame_err, 0);
    ser_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3 * 217) @(negedge clk);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_ferr", fe_cnt - f0, 0);
    check("midrst_idle", busy, 0);

    v0 = valid_cnt;
    apply(3, 6);
    drain("drain_small", 200);
    check("count_small", valid_cnt - v0, 4);
    check("data_small_last", data, 8'h00);

    cfg_divider = tab[7].cfg;
    exp_q.push_back(tab[7].exp_data);
    fork
      send_frame(tab[7].b, tab[7].bc, 1'b1);
      begin
        repeat (20) @(negedge clk);
        cfg_divider = 32'd200;
      end
    join
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    drain("drain_cfgchg", 200);
    check("data_cfgchg", data, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
